// File: rtl/baud_pkg.sv
// Shared constants, divisor configuration type and reset-divisor helper for the baud tick generator.
package baud_pkg;
   localparam real         DEF_CLOCK      = 100.0e6;
   localparam real         DEF_BAUD       = 115200.0;
   localparam int unsigned DEF_OVERSAMPLE = 16;
   localparam int unsigned CFG_DIVW       = 16;
   localparam int unsigned CFG_FRACW      = 4;

   typedef struct packed {
      logic [CFG_DIVW-1:0]  div;
      logic [CFG_FRACW-1:0] frac;
   } baud_cfg_t;

   // Truncating divide: clock cycles per oversample tick.
   function automatic int unsigned calc_div(input real clock, input real baud, input int unsigned os);
      return $unsigned($rtoi(clock / (baud * real'(os))));
   endfunction
endpackage

// File: rtl/baud_frac_acc.sv
// Fractional divisor accumulator: flags the next oversample period as one cycle longer on carry.
// The flag is registered, so it applies to the period that starts after the tick that carried.
module baud_frac_acc #(
   parameter int unsigned FRACW = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             tick_i,
   input  logic [FRACW-1:0] frac_i,
   output logic             long_o
);
   logic [FRACW-1:0] acc_q, acc_d;
   logic             long_q, long_d;

   always_comb begin
      acc_d  = acc_q;
      long_d = long_q;
      if (clear_i) begin
         acc_d  = '0;
         long_d = 1'b0;
      end else if (tick_i) begin
         {long_d, acc_d} = {1'b0, acc_q} + {1'b0, frac_i};
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc_q  <= '0;
         long_q <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         long_q <= long_d;
      end
   end

   assign long_o = long_q;
endmodule

// File: rtl/baud_tick_gen.sv
// Programmable baud generator: registered oversample, mid-bit and bit-end strobes, one cycle after terminal count.
// Divisor reloads only at bit boundaries or on clear_i; BAUD_FRAC_EN adds a fractional divisor.
module baud_tick_gen
   import baud_pkg::*;
#(
   parameter real         CLOCK      = DEF_CLOCK,
   parameter real         BAUD_RATE  = DEF_BAUD,
   parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE,
   parameter int unsigned DIVW       = CFG_DIVW,
   parameter int unsigned FRACW      = CFG_FRACW,
   parameter int unsigned DEF_DIV    = calc_div(CLOCK, BAUD_RATE, OVERSAMPLE)
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          en_i,
   input  logic                          clear_i,
   input  logic                          div_load_i,
   input  logic [DIVW-1:0]               div_i,
   input  logic [FRACW-1:0]              frac_i,
   output logic                          os_tick_o,
   output logic                          mid_tick_o,
   output logic                          bit_tick_o,
   output logic [$clog2(OVERSAMPLE)-1:0] os_idx_o
);
   localparam int unsigned     IDXW     = $clog2(OVERSAMPLE);
   localparam logic [IDXW-1:0] MID_IDX  = IDXW'(OVERSAMPLE / 2 - 1);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(OVERSAMPLE - 1);
   localparam baud_cfg_t       RST_CFG  = '{div: CFG_DIVW'(DEF_DIV), frac: '0};

   logic [DIVW-1:0] cnt_q, cnt_d;
   logic [IDXW-1:0] idx_q, idx_d;
   logic            os_q, os_d, mid_q, mid_d, bit_q, bit_d;
   baud_cfg_t       shadow_q, shadow_d, act_q, act_d, new_cfg;
   logic [DIVW-1:0] div_act, div_m1, term_cnt;
   logic            long_period, os_evt;

   assign new_cfg  = '{div: CFG_DIVW'(div_i), frac: CFG_FRACW'(frac_i)};
   assign div_act  = DIVW'(act_q.div);
   // Divisors of 0 and 1 both mean a tick every enabled cycle.
   assign div_m1   = (div_act > DIVW'(1)) ? div_act - DIVW'(1) : '0;
   assign term_cnt = div_m1 + DIVW'(long_period);
   assign os_evt   = en_i && !clear_i && (cnt_q == term_cnt);

   always_comb begin
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      os_d     = 1'b0;
      mid_d    = 1'b0;
      bit_d    = 1'b0;
      shadow_d = div_load_i ? new_cfg : shadow_q;
      act_d    = act_q;
      if (clear_i) begin
         cnt_d = '0;
         idx_d = '0;
         act_d = shadow_d;
      end else if (os_evt) begin
         cnt_d = '0;
         idx_d = idx_q + 1'b1;
         os_d  = 1'b1;
         mid_d = (idx_q == MID_IDX);
         bit_d = (idx_q == LAST_IDX);
         // Bit boundary: a load arriving in this very cycle already counts for the next bit.
         if (idx_q == LAST_IDX) begin
            act_d = shadow_d;
         end
      end else if (en_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q    <= '0;
         idx_q    <= '0;
         os_q     <= 1'b0;
         mid_q    <= 1'b0;
         bit_q    <= 1'b0;
         shadow_q <= RST_CFG;
         act_q    <= RST_CFG;
      end else begin
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         os_q     <= os_d;
         mid_q    <= mid_d;
         bit_q    <= bit_d;
         shadow_q <= shadow_d;
         act_q    <= act_d;
      end
   end

`ifdef BAUD_FRAC_EN
   baud_frac_acc #(.FRACW(FRACW)) u_frac_acc (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (clear_i),
      .tick_i  (os_evt),
      .frac_i  (FRACW'(act_d.frac)),
      .long_o  (long_period)
   );
`else
   logic unused_frac;
   assign long_period = 1'b0;
   assign unused_frac = ^act_q.frac;
`endif

   assign os_tick_o  = os_q;
   assign mid_tick_o = mid_q;
   assign bit_tick_o = bit_q;
   assign os_idx_o   = idx_q;
endmodule

// File: tb/tb_baud_tick_gen.sv
// Bench for baud_tick_gen: default-rate instance plus an OVERSAMPLE=4 instance checked against a tick scoreboard.
module tb_baud_tick_gen;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic rst_n;
   // default-parameter instance
   logic        d_en, d_clr, d_ld;
   logic [15:0] d_div;
   logic [3:0]  d_frac;
   logic        d_os, d_mid, d_bt;
   logic [3:0]  d_idx;
   // OVERSAMPLE=4 instance
   logic        en, clr, ld;
   logic [15:0] div;
   logic [3:0]  frac;
   logic        f_os, f_mid, f_bt;
   logic [1:0]  f_idx;

   baud_tick_gen u_def (
      .clk_i(clk), .rst_ni(rst_n), .en_i(d_en), .clear_i(d_clr), .div_load_i(d_ld),
      .div_i(d_div), .frac_i(d_frac), .os_tick_o(d_os), .mid_tick_o(d_mid),
      .bit_tick_o(d_bt), .os_idx_o(d_idx));

   baud_tick_gen #(.OVERSAMPLE(4)) u_os4 (
      .clk_i(clk), .rst_ni(rst_n), .en_i(en), .clear_i(clr), .div_load_i(ld),
      .div_i(div), .frac_i(frac), .os_tick_o(f_os), .mid_tick_o(f_mid),
      .bit_tick_o(f_bt), .os_idx_o(f_idx));

   int checks = 0;
   int errors = 0;

   typedef struct { int cyc; logic [1:0] idx; logic mid; logic bt; } exp_t;
   exp_t sb[$];
   exp_t mon_e;
   bit   mon_on = 1'b0;

   always @(negedge clk) begin
      if (mon_on && f_os) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected tick at cyc=%0d idx=%0d, expected none", cyc, f_idx);
         end else begin
            mon_e = sb.pop_front();
            if (mon_e.cyc != cyc || mon_e.idx != f_idx || mon_e.mid != f_mid || mon_e.bt != f_bt) begin
               errors++;
               $display("FAIL sb_tick got cyc=%0d idx=%0d mid=%0b bit=%0b expected cyc=%0d idx=%0d mid=%0b bit=%0b",
                        cyc, f_idx, f_mid, f_bt, mon_e.cyc, mon_e.idx, mon_e.mid, mon_e.bt);
            end
         end
      end
   end

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d", name, got, exp);
      end
   endtask

   task automatic step_to(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   // k = os tick number since the last clear; index after the tick is k mod 4
   function automatic void push(input int t, input int k);
      exp_t e;
      e.cyc = t;
      e.idx = 2'(k % 4);
      e.mid = ((k % 4) == 2);
      e.bt  = ((k % 4) == 0);
      sb.push_back(e);
   endfunction

   task automatic start(input logic [15:0] dv, input logic [3:0] fr, output int t0);
      @(negedge clk);
      clr = 1'b1; ld = 1'b1; div = dv; frac = fr; en = 1'b1;
      @(negedge clk);
      clr = 1'b0; ld = 1'b0;
      t0 = cyc;
   endtask

   task automatic finish_phase(input string name, input int tlast);
      step_to(tlast);
      en = 1'b0;
      step_to(tlast + 3);
      chk(name, sb.size(), 0);
      sb.delete();
   endtask

   typedef struct { logic [15:0] dv; int per; int n; } vec_t;
   vec_t vt[5];

   initial begin
      int t0, r, first_os, bad, os4_ticks, iv, prev_iv;
      int mids[$];
      int bits[$];
      int times[$];

      vt[0] = '{16'd5, 5, 8};
      vt[1] = '{16'd0, 1, 9};
      vt[2] = '{16'd1, 1, 8};
      vt[3] = '{16'd3, 3, 8};
      vt[4] = '{16'd2, 2, 6};

      rst_n = 1'b0;
      d_en = 1'b1; d_clr = 1'b0; d_ld = 1'b0; d_div = '0; d_frac = '0;
      en = 1'b0; clr = 1'b0; ld = 1'b0; div = '0; frac = '0;
      repeat (3) @(negedge clk);
      chk("reset_def_outputs", int'({d_os, d_mid, d_bt, d_idx}), 0);
      chk("reset_os4_outputs", int'({f_os, f_mid, f_bt, f_idx}), 0);

      // Default rate: DEF_DIV = 54, 16 ticks per bit
      rst_n = 1'b1;
      r = cyc;
      first_os = -1; bad = 0; os4_ticks = 0;
      while (cyc < r + 1800) begin
         @(negedge clk);
         if (d_os && first_os < 0) first_os = cyc;
         if (d_mid) mids.push_back(cyc);
         if (d_bt) bits.push_back(cyc);
         if ((d_mid && d_bt) || ((d_mid || d_bt) && !d_os)) bad++;
         if (f_os) os4_ticks++;
      end
      chk("def_first_os", first_os - r, 54);
      chk("def_bit_count", bits.size(), 2);
      chk("def_mid_count", mids.size(), 2);
      chk("def_bit0", (bits.size() > 0) ? bits[0] - r : -1, 864);
      chk("def_bit1", (bits.size() > 1) ? bits[1] - r : -1, 1728);
      chk("def_mid0", (mids.size() > 0) ? mids[0] - r : -1, 432);
      chk("def_mid_after_bit", (mids.size() > 1 && bits.size() > 0) ? mids[1] - bits[0] : -1, 432);
      chk("def_strobe_exclusive", bad, 0);
      chk("os4_disabled_no_ticks", os4_ticks, 0);
      d_en = 1'b0;

      mon_on = 1'b1;
      // Table: constant divisor, period and tick count after clear+load
      for (int i = 0; i < 5; i++) begin
         start(vt[i].dv, 4'd0, t0);
         for (int k = 1; k <= vt[i].n; k++) push(t0 + k * vt[i].per, k);
         finish_phase("table_drain", t0 + vt[i].n * vt[i].per);
      end

      // Mid-bit reload waits for the boundary; a load on the boundary applies at once
      start(16'd5, 4'd0, t0);
      for (int k = 1; k <= 4; k++)  push(t0 + 5 * k, k);
      for (int k = 5; k <= 12; k++) push(t0 + 20 + 3 * (k - 4), k);
      for (int k = 13; k <= 16; k++) push(t0 + 44 + 5 * (k - 12), k);
      step_to(t0 + 6);  ld = 1'b1; div = 16'd3;
      step_to(t0 + 7);  ld = 1'b0;
      step_to(t0 + 43); ld = 1'b1; div = 16'd5;
      step_to(t0 + 44); ld = 1'b0;
      finish_phase("reload_drain", t0 + 64);

      // en_i hold for 7 cycles, then clear_i with en_i high
      start(16'd5, 4'd0, t0);
      push(t0 + 5, 1); push(t0 + 10, 2); push(t0 + 22, 3); push(t0 + 27, 4);
      push(t0 + 32, 5); push(t0 + 40, 1); push(t0 + 45, 2);
      step_to(t0 + 12); en = 1'b0;
      step_to(t0 + 16);
      chk("hold_idx", int'(f_idx), 2);
      step_to(t0 + 19); en = 1'b1;
      step_to(t0 + 34); clr = 1'b1;
      step_to(t0 + 35); clr = 1'b0;
      chk("clear_idx", int'(f_idx), 0);
      chk("clear_no_tick", int'(f_os), 0);
      finish_phase("hold_clear_drain", t0 + 45);
      mon_on = 1'b0;

      // Fractional divisor 5 + 8/16
      start(16'd5, 4'd8, t0);
      while (times.size() < 34 && cyc < t0 + 400) begin
         @(negedge clk);
         if (f_os) times.push_back(cyc);
      end
      en = 1'b0;
      chk("frac_tick_count", times.size(), 34);
      if (times.size() == 34) begin
         prev_iv = 0;
         for (int i = 1; i <= 32; i++) begin
            iv = times[i + 1] - times[i];
`ifdef BAUD_FRAC_EN
            chk("frac_alternate", int'((iv == 5 || iv == 6) && iv != prev_iv), 1);
`else
            chk("frac_ignored_period", iv, 5);
`endif
            prev_iv = iv;
         end
`ifdef BAUD_FRAC_EN
         chk("frac_total_32", times[33] - times[1], 176);
`else
         chk("frac_total_32", times[33] - times[1], 160);
`endif
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/baud_tick_gen.md
Name: baud_tick_gen

Overview:
- Parametrised successor of the single-rate baud counter.
- Produces single-cycle oversample, mid-bit and bit-boundary strobes from one system clock.
- The divisor is programmable at runtime and reloads cleanly at period boundaries.
- Feeds both the UART transmitter (bit_tick_o) and a future receiver (os_tick_o, mid_tick_o) from one shared generator.

Parameters:
- CLOCK, 100e6, system clock frequency in Hz.
- BAUD_RATE, 115200, default baud rate used to compute the reset divisor.
- OVERSAMPLE, 16, oversample ticks per bit; must be >= 2 and a power of 2.
- DIVW, 16, width of the divisor register.
- FRACW, 4, fractional divisor width; used only with BAUD_FRAC_EN.
- DEF_DIV, CLOCK/(BAUD_RATE*OVERSAMPLE) truncated (54 at defaults), divisor loaded at reset.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  asynchronous active-low reset.
- en_i  in  1  count enable; when low, all counters hold.
- clear_i  in  1  synchronous restart of all counters.
- div_load_i  in  1  one-cycle strobe that captures div_i (and frac_i) into the shadow register.
- div_i  in  DIVW  new integer divisor (clock cycles per oversample tick).
- frac_i  in  FRACW  fractional divisor in 1/2^FRACW units; ignored without BAUD_FRAC_EN.
- os_tick_o  out  1  oversample strobe.
- mid_tick_o  out  1  strobe at the middle of a bit (oversample index OVERSAMPLE/2-1 wrapping).
- bit_tick_o  out  1  strobe at the end of a bit (oversample index OVERSAMPLE-1 wrapping).
- os_idx_o  out  $clog2(OVERSAMPLE)  current oversample index within the bit.

Behaviour:
- Reset (rst_ni low, asynchronous):
  - Cycle counter, os_idx_o and all ticks go to 0.
  - Active and shadow divisors go to DEF_DIV; fraction and accumulator go to 0.
- Cycle counter:
  - Counts 0..div_act-1 while en_i=1.
  - At count == div_act-1: os_tick_o=1 for exactly one cycle, registered, asserted in the cycle after the terminal count is reached; the counter wraps to 0.
- Divisor clamping: div_act of 0 or 1 is treated as 1, so os_tick_o is asserted every enabled cycle.
- Oversample index: os_idx_o increments on every os tick and wraps OVERSAMPLE-1 -> 0.
- mid_tick_o is asserted together with the os tick that moves the index from OVERSAMPLE/2-1 to OVERSAMPLE/2.
- bit_tick_o is asserted together with the os tick that wraps the index to 0.
- At most one of mid_tick_o and bit_tick_o is high in any cycle; os_tick_o is always high whenever either of them is.
- Divisor reload:
  - div_load_i writes the shadow register.
  - The shadow copies into div_act only at a bit boundary, i.e. in the same cycle bit_tick_o is generated. The current bit always completes at the old rate.
  - If div_load_i coincides with that boundary, the new value is used immediately for the next bit.
- en_i low: counter and index hold their values, all ticks are 0, and div_load_i is still accepted.
- clear_i:
  - Has priority over en_i and over boundary events.
  - Cycle counter, index and accumulator go to 0; ticks are 0 in the following cycle.
  - The shadow register is copied into div_act, so clear_i with div_load_i in the same cycle applies the new divisor immediately.
- Counter width is DIVW. No overflow is possible because div_act <= 2^DIVW-1.

Optional Feature:
- Macro: BAUD_FRAC_EN.
- Defined:
  - Adds a FRACW-bit accumulator, frac_i and a shadow fraction.
  - On each os tick the accumulator adds frac_act. When that add carries, the next os period lasts div_act+1 cycles.
  - Average period is div_act + frac_act/2^FRACW. For example, div=54, frac=4 gives 54.25, i.e. 115200 baud at 100 MHz with OVERSAMPLE=16.
  - The fraction reloads under the same rules as the divisor.
- Undefined: the frac_i port is present but ignored, no accumulator is built, and every period is exactly div_act cycles.

Decomposition:
- Package baud_pkg holds:
  - the default constants (DEF_CLOCK, DEF_BAUD, DEF_OVERSAMPLE);
  - the function calc_div(clock, baud, os);
  - the typedef baud_cfg_t, a packed struct of div and frac.
- One natural sub-module, baud_frac_acc, holds the accumulator and carry logic. It is instantiated only under BAUD_FRAC_EN.

Test Plan:
- Reset, then release with defaults (DEF_DIV=54): first os_tick_o 54 cycles after release. bit_tick_o every 864 cycles. mid_tick_o 432 cycles after each bit_tick_o.
- OVERSAMPLE=4, load div=5: os ticks every 5 cycles. mid_tick_o on the 2nd os tick and bit_tick_o on the 4th. os_idx_o sequence 0,1,2,3,0.
- Load div=3 mid-bit: the current bit finishes with 5-cycle periods, and the first os period after bit_tick_o is 3 cycles. Repeat with div_load_i coinciding with bit_tick_o: the new rate applies immediately.
- Drop en_i for 7 cycles mid-period: counter and index frozen, no ticks, and the period resumes with the remaining count. Assert clear_i together with en_i=1: index returns to 0 and the next os tick comes a full div cycles later.
- Load div=0 and div=1: os_tick_o is high every enabled cycle, and bit_tick_o appears every OVERSAMPLE cycles.
- BAUD_FRAC_EN, div=5, frac=8, FRACW=4: os periods alternate 5,6,5,6. Over 32 os ticks the total is exactly 176 cycles.
